regfile_wb_arbiter: RTL

//  Shares the register file's single write port among NREQ write-back sources.

---
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// write-back sources, with a registered write port that holds while the regfile stalls.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wr_stall,
    output logic                 wr_en,
    output logic [4:0]           wr_addr,
    output logic [31:0]          wr_data,
    output logic [CNTW-1:0]      grant_cnt
);
    localparam int PW = $clog2(NREQ);

    // HOLD is WRITE observed with wr_stall high, so only wr_en needs to be stored.
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, gidx, cand, ptr_nxt;
    logic            found, xfer, commit;
    logic [4:0]      g_rd;
    logic [31:0]     g_data;
    logic [4:0]      rd_arr   [NREQ];
    logic [31:0]     data_arr [NREQ];
    int              idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd[5*i +: 5];
        assign data_arr[i] = req_data[32*i +: 32];
    end

    // First valid requester scanning circularly from rr_ptr.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = idx[PW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    assign g_rd    = rd_arr[gidx];
    assign g_data  = data_arr[gidx];
    assign xfer    = found && !wr_stall && !reset;
    assign commit  = xfer && (g_rd != 5'd0);
    assign ptr_nxt = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
    assign wr_en   = (state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!wr_stall) state_nxt = commit ? WRITE : IDLE;
    end

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            grant_cnt <= '0;
        end else begin
            if (xfer) rr_ptr <= ptr_nxt;
            if (commit) begin
                wr_addr   <= g_rd;
                wr_data   <= g_data;
                grant_cnt <= grant_cnt + CNTW'(1);
            end
        end
    end
endmodule
